// File: rtl/iso_pg_seq.sv
// Per-channel power-gating sequencer with output isolation clamps.
// Define ISO_HOLD_LAST_EN to clamp to the last passed result instead of zeros.
module iso_pg_seq #(
    parameter int NCH      = 2,
    parameter int DW       = 32,
    parameter int CW       = 2,
    parameter int TW       = 12,
    parameter int WAKE_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH*DW-1:0] rslt,
    input  logic [NCH*CW-1:0] rslt_cc,
    input  logic [NCH*TW-1:0] rslt_tag,
    input  logic [NCH-1:0]    rslt_vld,
    input  logic [NCH-1:0]    sleep_req,
    input  logic [NCH-1:0]    wake_req,
    output logic [NCH-1:0]    pwr_en,
    output logic [NCH-1:0]    iso_pass,
    output logic [NCH*DW-1:0] iso_rslt,
    output logic [NCH*CW-1:0] iso_rslt_cc,
    output logic [NCH*TW-1:0] iso_rslt_tag,
    output logic [NCH-1:0]    iso_rslt_vld
);

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_CLAMP  = 2'd1,
        ST_OFF    = 2'd2,
        ST_WAKE   = 2'd3
    } state_t;

    localparam logic [7:0] WAKE_LOAD = 8'(WAKE_CYC - 1);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        state_t         r_state;
        logic [7:0]     r_wakeCnt;
        logic           r_pwrEn;
        logic           r_isoPass;
        logic [DW-1:0]  w_clampRslt;
        logic [CW-1:0]  w_clampCc;
        logic [TW-1:0]  w_clampTag;

        // Outputs are updated together with the state so they always match its decode.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_state   <= ST_ACTIVE;
                r_wakeCnt <= 8'd0;
                r_pwrEn   <= 1'b1;
                r_isoPass <= 1'b1;
            end else begin
                case (r_state)
                    ST_ACTIVE: begin
                        if (sleep_req[i] && !wake_req[i] && !rslt_vld[i]) begin
                            r_state   <= ST_CLAMP;
                            r_isoPass <= 1'b0;
                        end
                    end
                    ST_CLAMP: begin
                        r_state <= ST_OFF;
                        r_pwrEn <= 1'b0;
                    end
                    ST_OFF: begin
                        if (wake_req[i]) begin
                            r_state   <= ST_WAKE;
                            r_pwrEn   <= 1'b1;
                            r_wakeCnt <= WAKE_LOAD;
                        end
                    end
                    ST_WAKE: begin
                        if (r_wakeCnt == 8'd0) begin
                            r_state   <= ST_ACTIVE;
                            r_isoPass <= 1'b1;
                        end else begin
                            r_wakeCnt <= r_wakeCnt - 8'd1;
                        end
                    end
                    default: begin
                        r_state   <= ST_ACTIVE;
                        r_pwrEn   <= 1'b1;
                        r_isoPass <= 1'b1;
                    end
                endcase
            end
        end

`ifdef ISO_HOLD_LAST_EN
        logic [DW-1:0] r_holdRslt;
        logic [CW-1:0] r_holdCc;
        logic [TW-1:0] r_holdTag;

        // Snapshot every result that actually crosses the isolation boundary.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_holdRslt <= '0;
                r_holdCc   <= '0;
                r_holdTag  <= '0;
            end else if (r_isoPass && rslt_vld[i]) begin
                r_holdRslt <= rslt[i*DW +: DW];
                r_holdCc   <= rslt_cc[i*CW +: CW];
                r_holdTag  <= rslt_tag[i*TW +: TW];
            end
        end

        assign w_clampRslt = r_holdRslt;
        assign w_clampCc   = r_holdCc;
        assign w_clampTag  = r_holdTag;
`else
        assign w_clampRslt = '0;
        assign w_clampCc   = '0;
        assign w_clampTag  = '0;
`endif

        assign pwr_en[i]   = r_pwrEn;
        assign iso_pass[i] = r_isoPass;

        assign iso_rslt[i*DW +: DW]     = r_isoPass ? rslt[i*DW +: DW]     : w_clampRslt;
        assign iso_rslt_cc[i*CW +: CW]  = r_isoPass ? rslt_cc[i*CW +: CW]  : w_clampCc;
        assign iso_rslt_tag[i*TW +: TW] = r_isoPass ? rslt_tag[i*TW +: TW] : w_clampTag;
        // Reset gates valid directly since the registered pass flag may still be open.
        assign iso_rslt_vld[i] = rslt_vld[i] & r_isoPass & ~rst;
    end

endmodule

// File: tb/tb_iso_pg_seq.sv
// Directed testbench for iso_pg_seq (NCH=2, WAKE_CYC=4); honours ISO_HOLD_LAST_EN.
module tb_iso_pg_seq;

`ifdef ISO_HOLD_LAST_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] rslt;
    logic [3:0]  rslt_cc;
    logic [23:0] rslt_tag;
    logic [1:0]  rslt_vld, sleep_req, wake_req;
    logic [1:0]  pwr_en, iso_pass, iso_rslt_vld;
    logic [63:0] iso_rslt;
    logic [3:0]  iso_rslt_cc;
    logic [23:0] iso_rslt_tag;

    int testsRun  = 0;
    int failCount = 0;

    iso_pg_seq #(.NCH(2), .DW(32), .CW(2), .TW(12), .WAKE_CYC(4)) dut (
        .clk(clk), .rst(rst),
        .rslt(rslt), .rslt_cc(rslt_cc), .rslt_tag(rslt_tag), .rslt_vld(rslt_vld),
        .sleep_req(sleep_req), .wake_req(wake_req),
        .pwr_en(pwr_en), .iso_pass(iso_pass),
        .iso_rslt(iso_rslt), .iso_rslt_cc(iso_rslt_cc), .iso_rslt_tag(iso_rslt_tag),
        .iso_rslt_vld(iso_rslt_vld)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; rslt = '0; rslt_cc = '0; rslt_tag = '0;
        rslt_vld = '0; sleep_req = '0; wake_req = '0;
        tick(); tick();
        checkOutput("rst_pwr_en", 64'(pwr_en), 64'h3);
        checkOutput("rst_iso_pass", 64'(iso_pass), 64'h3);
        rslt_vld = 2'b11; #1;
        checkOutput("rst_vld_gated", 64'(iso_rslt_vld), 64'h0);

        rst = 1'b0; rslt_vld = 2'b00;
        tick();
        rslt = {32'h22222222, 32'hDEADBEEF};
        rslt_cc = {2'b01, 2'b10};
        rslt_tag = {12'h333, 12'h5A5};
        rslt_vld = 2'b11; #1;
        checkOutput("pass_rslt", iso_rslt, {32'h22222222, 32'hDEADBEEF});
        checkOutput("pass_cc", 64'(iso_rslt_cc), 64'h6);
        checkOutput("pass_tag", 64'(iso_rslt_tag), 64'h3335A5);
        checkOutput("pass_vld", 64'(iso_rslt_vld), 64'h3);

        // Drain: sleep with valid held high keeps ch0 active.
        sleep_req = 2'b01;
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("drain_iso_pass0", 64'(iso_pass[0]), 64'h1);
            checkOutput("drain_pwr_en0", 64'(pwr_en[0]), 64'h1);
        end
        rslt_vld = 2'b10;
        tick();
        checkOutput("clamp_iso_pass", 64'(iso_pass), 64'h2);
        checkOutput("clamp_pwr_en", 64'(pwr_en), 64'h3);
        rslt[31:0] = 32'h12345678; rslt_cc[1:0] = 2'b11; rslt_tag[11:0] = 12'hFFF;
        rslt_vld = 2'b11; #1;
        checkOutput("clamp_rslt0", 64'(iso_rslt[31:0]), HOLD ? 64'hDEADBEEF : 64'h0);
        checkOutput("clamp_cc0", 64'(iso_rslt_cc[1:0]), HOLD ? 64'h2 : 64'h0);
        checkOutput("clamp_tag0", 64'(iso_rslt_tag[11:0]), HOLD ? 64'h5A5 : 64'h0);
        checkOutput("clamp_rslt1", 64'(iso_rslt[63:32]), 64'h22222222);
        checkOutput("clamp_vld", 64'(iso_rslt_vld), 64'h2);
        wake_req = 2'b01;
        tick();
        checkOutput("off_pwr_en", 64'(pwr_en), 64'h2);
        checkOutput("off_iso_pass", 64'(iso_pass), 64'h2);
        wake_req = 2'b00; rslt_vld = 2'b00;
        tick();
        checkOutput("off_stays", 64'(pwr_en[0]), 64'h0);
        sleep_req = 2'b00;

        // Wake sequence: power back after one edge, isolation opens after four more.
        rslt[31:0] = 32'hCAFEF00D;
        wake_req = 2'b01;
        tick();
        wake_req = 2'b00;
        checkOutput("wake_pwr_en0", 64'(pwr_en[0]), 64'h1);
        checkOutput("wake_cnt_load", 64'(dut.g_ch[0].r_wakeCnt), 64'h3);
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) tick();
            checkOutput("wake_iso_pass0", 64'(iso_pass[0]), 64'h0);
            checkOutput("wake_rslt0", 64'(iso_rslt[31:0]), HOLD ? 64'hDEADBEEF : 64'h0);
        end
        tick();
        checkOutput("wake_done_pass", 64'(iso_pass), 64'h3);
        checkOutput("wake_done_rslt0", 64'(iso_rslt[31:0]), 64'hCAFEF00D);

        // Plain sleep with no result in flight.
        sleep_req = 2'b01;
        tick();
        sleep_req = 2'b00;
        checkOutput("sleep_iso_pass", 64'(iso_pass), 64'h2);
        checkOutput("sleep_pwr_en", 64'(pwr_en), 64'h3);
        tick();
        checkOutput("sleep_off_pwr_en", 64'(pwr_en), 64'h2);

        // Conflicting requests on ch1 never leave ACTIVE.
        sleep_req = 2'b10; wake_req = 2'b10;
        for (int k = 0; k < 10; k++) begin
            tick();
            checkOutput("both_pwr_en1", 64'(pwr_en[1]), 64'h1);
            checkOutput("both_iso_pass1", 64'(iso_pass[1]), 64'h1);
        end
        sleep_req = 2'b00; wake_req = 2'b00;

        // Reset in the middle of a wake.
        wake_req = 2'b01;
        tick();
        wake_req = 2'b00;
        tick();
        checkOutput("mid_wake_cnt", 64'(dut.g_ch[0].r_wakeCnt), 64'h2);
        checkOutput("mid_wake_pass", 64'(iso_pass[0]), 64'h0);
        rst = 1'b1; rslt_vld = 2'b11;
        tick();
        checkOutput("mid_rst_pwr_en", 64'(pwr_en), 64'h3);
        checkOutput("mid_rst_iso_pass", 64'(iso_pass), 64'h3);
        checkOutput("mid_rst_cnt", 64'(dut.g_ch[0].r_wakeCnt), 64'h0);
        checkOutput("mid_rst_vld", 64'(iso_rslt_vld), 64'h0);
        rst = 1'b0; rslt_vld = 2'b00;
        tick();
        checkOutput("post_rst_pass", 64'(iso_pass), 64'h3);

        // Hold registers were cleared by reset, so a fresh clamp on ch1 reads zero.
        sleep_req = 2'b10;
        tick();
        sleep_req = 2'b00;
        checkOutput("hold_clr_pass", 64'(iso_pass), 64'h1);
        checkOutput("hold_clr_rslt1", 64'(iso_rslt[63:32]), 64'h0);
        checkOutput("hold_clr_tag1", 64'(iso_rslt_tag[23:12]), 64'h0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
